// File: rtl/lr_mem_if.sv
// Requester, read-data and RAM-side signals of the x/y sample memory scheduler.
interface lr_mem_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 20,
    parameter int LEN_W  = 9
) ();
    logic              w_req;
    logic [ADDR_W-1:0] w_base;
    logic [LEN_W-1:0]  w_len;
    logic [DATA_W-1:0] w_x;
    logic [DATA_W-1:0] w_y;
    logic              w_gnt;
    logic              w_done;

    logic              c_req;
    logic [ADDR_W-1:0] c_base;
    logic [LEN_W-1:0]  c_len;
    logic              c_gnt;
    logic              c_valid;
    logic              c_done;

    logic              e_req;
    logic [ADDR_W-1:0] e_base;
    logic [LEN_W-1:0]  e_len;
    logic              e_gnt;
    logic              e_valid;
    logic              e_done;

    logic [DATA_W-1:0] rd_x;
    logic [DATA_W-1:0] rd_y;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_wx;
    logic [DATA_W-1:0] mem_wy;
    logic [DATA_W-1:0] mem_rx;
    logic [DATA_W-1:0] mem_ry;

    modport slave (
        input  w_req, w_base, w_len, w_x, w_y,
        input  c_req, c_base, c_len,
        input  e_req, e_base, e_len,
        input  mem_rx, mem_ry,
        output w_gnt, w_done,
        output c_gnt, c_valid, c_done,
        output e_gnt, e_valid, e_done,
        output rd_x, rd_y,
        output mem_addr, mem_we, mem_re, mem_wx, mem_wy
    );

    modport master (
        output w_req, w_base, w_len, w_x, w_y,
        output c_req, c_base, c_len,
        output e_req, e_base, e_len,
        output mem_rx, mem_ry,
        input  w_gnt, w_done,
        input  c_gnt, c_valid, c_done,
        input  e_gnt, e_valid, e_done,
        input  rd_x, rd_y,
        input  mem_addr, mem_we, mem_re, mem_wx, mem_wy
    );
endinterface

// File: rtl/lr_mem_scheduler.sv
// Burst scheduler for the shared x/y sample RAM: writer W has priority,
// readers C and E alternate round-robin; one burst owns the RAM until done.
module lr_mem_scheduler #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 20,
    parameter int LEN_W  = 9
) (
    input  logic   clk,
    input  logic   rst,
    lr_mem_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_WBURST, S_RBURST, S_DRAIN, S_DONEZ
    } state_e;

    typedef enum logic [1:0] {R_W, R_C, R_E} who_e;

    localparam logic [DATA_W-1:0] ZERO_D = '0;

    state_e            state_q, state_d;
    who_e              who_q, who_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              rr_q, rr_d;
    logic              valid_q, valid_d;
    logic              go;
    logic              re;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            who_q   <= R_C;
            addr_q  <= '0;
            rem_q   <= '0;
            rr_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            who_q   <= who_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            rr_q    <= rr_d;
            valid_q <= valid_d;
        end
    end

    assign bus.mem_re = re;
    assign bus.rd_x   = bus.mem_rx;
    assign bus.rd_y   = bus.mem_ry;

    always_comb begin
        state_d      = state_q;
        who_d        = who_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        rr_d         = rr_q;
        go           = 1'b0;
        re           = 1'b0;
        bus.w_gnt    = 1'b0;
        bus.w_done   = 1'b0;
        bus.c_gnt    = 1'b0;
        bus.c_done   = 1'b0;
        bus.e_gnt    = 1'b0;
        bus.e_done   = 1'b0;
        bus.mem_addr = '0;
        bus.mem_we   = 1'b0;
        bus.mem_wx   = ZERO_D;
        bus.mem_wy   = ZERO_D;

        unique case (state_q)
            S_IDLE: begin
                // rr_q set means E is owed the next contested read grant
                if (bus.w_req) begin
                    who_d  = R_W;
                    addr_d = bus.w_base;
                    rem_d  = bus.w_len;
                    go     = 1'b1;
                end else if (bus.c_req && !(bus.e_req && rr_q)) begin
                    who_d  = R_C;
                    addr_d = bus.c_base;
                    rem_d  = bus.c_len;
                    rr_d   = 1'b1;
                    go     = 1'b1;
                end else if (bus.e_req) begin
                    who_d  = R_E;
                    addr_d = bus.e_base;
                    rem_d  = bus.e_len;
                    rr_d   = 1'b0;
                    go     = 1'b1;
                end
                if (go) begin
                    if (rem_d == '0)
                        state_d = S_DONEZ;
                    else if (who_d == R_W)
                        state_d = S_WBURST;
                    else
                        state_d = S_RBURST;
                end
            end
            S_WBURST: begin
                bus.w_gnt    = 1'b1;
                bus.mem_we   = 1'b1;
                bus.mem_addr = addr_q;
                bus.mem_wx   = bus.w_x;
                bus.mem_wy   = bus.w_y;
                addr_d       = addr_q + 1'b1;
                rem_d        = rem_q - 1'b1;
                if (rem_q == LEN_W'(1)) begin
                    bus.w_done = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            S_RBURST: begin
                re           = 1'b1;
                bus.mem_addr = addr_q;
                bus.c_gnt    = (who_q == R_C);
                bus.e_gnt    = (who_q == R_E);
                addr_d       = addr_q + 1'b1;
                rem_d        = rem_q - 1'b1;
                if (rem_q == LEN_W'(1))
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                bus.c_done = (who_q == R_C);
                bus.e_done = (who_q == R_E);
                state_d    = S_IDLE;
            end
            S_DONEZ: begin
                bus.w_done = (who_q == R_W);
                bus.c_done = (who_q == R_C);
                bus.e_done = (who_q == R_E);
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        valid_d     = re;
        bus.c_valid = valid_q && (who_q == R_C);
        bus.e_valid = valid_q && (who_q == R_E);
    end
endmodule

// File: tb/tb_lr_mem_scheduler.sv
// Self-checking bench for lr_mem_scheduler: directed table, corner sequences,
// and randomized traffic against a burst-level schedule model.
`timescale 1ns/1ps
module tb_lr_mem_scheduler;
    localparam int AW = 8;
    localparam int DW = 20;
    localparam int LW = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lr_mem_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

    lr_mem_scheduler #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] ram_x [256];
    logic [DW-1:0] ram_y [256];
    logic [DW-1:0] ex_x  [256];
    logic [DW-1:0] ex_y  [256];
    logic          ram_init = 1'b0;

    function automatic logic [DW-1:0] px(int i);
        return DW'(i * 311 + 5);
    endfunction

    function automatic logic [DW-1:0] py(int i);
        return DW'(20'hA5A5A ^ (i * 17));
    endfunction

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) begin
                ram_x[i] <= px(i);
                ram_y[i] <= py(i);
            end
        end else begin
            if (bus.mem_we) begin
                ram_x[bus.mem_addr] <= bus.mem_wx;
                ram_y[bus.mem_addr] <= bus.mem_wy;
            end
            if (bus.mem_re) begin
                bus.mem_rx <= ram_x[bus.mem_addr];
                bus.mem_ry <= ram_y[bus.mem_addr];
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // {w_gnt,w_done,c_gnt,c_valid,c_done,e_gnt,e_valid,e_done,we,re,addr}
    function automatic logic [17:0] outs();
        return {bus.w_gnt, bus.w_done, bus.c_gnt, bus.c_valid, bus.c_done,
                bus.e_gnt, bus.e_valid, bus.e_done, bus.mem_we, bus.mem_re,
                bus.mem_addr};
    endfunction

    function automatic logic [17:0] mk(int who, logic g, logic v, logic d,
                                       logic we, logic re, logic [7:0] a);
        logic [17:0] r;
        r = '0;
        case (who)
            0: begin r[17] = g; r[16] = d; end
            1: begin r[15] = g; r[14] = v; r[13] = d; end
            2: begin r[12] = g; r[11] = v; r[10] = d; end
            default: ;
        endcase
        r[9] = we;
        r[8] = re;
        r[7:0] = a;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int who, input logic on,
                           input logic [7:0] base, input int len);
        case (who)
            0: begin bus.w_req = on; bus.w_base = base; bus.w_len = LW'(len); end
            1: begin bus.c_req = on; bus.c_base = base; bus.c_len = LW'(len); end
            default: begin
                bus.e_req = on; bus.e_base = base; bus.e_len = LW'(len);
            end
        endcase
    endtask

    logic favor_e;

    task automatic do_reset();
        rst = 1'b1;
        ram_init = 1'b1;
        bus.w_req = 0; bus.c_req = 0; bus.e_req = 0;
        bus.w_base = 0; bus.c_base = 0; bus.e_base = 0;
        bus.w_len = 0; bus.c_len = 0; bus.e_len = 0;
        bus.w_x = 0; bus.w_y = 0;
        for (int i = 0; i < 256; i++) begin
            ex_x[i] = px(i);
            ex_y[i] = py(i);
        end
        favor_e = 1'b0;
        repeat (2) tick();
        #1;
        check("reset_outs", 64'(outs()), 64'(0));
        rst = 1'b0;
        ram_init = 1'b0;
    endtask

    typedef struct {
        int         who;
        logic [7:0] base;
        int         len;
        int         done_cyc;
        logic [7:0] last_addr;
    } vec_t;

    task automatic run_entry(input string tag, input vec_t e);
        int errs, done_at, ndone;
        logic [7:0] last;
        logic [17:0] act, exp, bad_act, bad_exp;
        logic ew, er, ev, ed;
        logic [7:0] ea;
        errs = 0; done_at = -1; ndone = 0; last = 0;
        bad_act = 0; bad_exp = 0;
        tick();
        set_req(e.who, 1'b1, e.base, e.len);
        for (int cyc = 1; cyc <= e.len + 4; cyc++) begin
            tick();
            bus.w_x = DW'($urandom);
            bus.w_y = DW'($urandom);
            #1;
            ew = (e.who == 0) && (cyc <= e.len);
            er = (e.who != 0) && (cyc <= e.len);
            ev = (e.who != 0) && (cyc >= 2) && (cyc <= e.len + 1);
            if (e.len == 0) ed = (cyc == 1);
            else if (e.who == 0) ed = (cyc == e.len);
            else ed = (cyc == e.len + 1);
            ea = (ew || er) ? e.base + 8'(cyc - 1) : 8'h00;
            exp = mk(e.who, ew || er, ev, ed, ew, er, ea);
            act = outs();
            if (act !== exp) begin
                if (errs == 0) begin bad_act = act; bad_exp = exp; end
                errs++;
            end
            if (ev && (bus.rd_x !== ex_x[e.base + 8'(cyc - 2)] ||
                       bus.rd_y !== ex_y[e.base + 8'(cyc - 2)]))
                errs++;
            if (ew) begin
                if (bus.mem_wx !== bus.w_x || bus.mem_wy !== bus.w_y) errs++;
                ex_x[ea] = bus.w_x;
                ex_y[ea] = bus.w_y;
            end
            if (bus.mem_we || bus.mem_re) last = bus.mem_addr;
            if (bus.w_done || bus.c_done || bus.e_done) begin
                done_at = cyc;
                ndone++;
                set_req(e.who, 1'b0, e.base, e.len);
            end
        end
        set_req(e.who, 1'b0, 8'h00, 0);
        if (errs != 0)
            $display("first bad cycle in %s: act=%0h exp=%0h", tag, bad_act, bad_exp);
        check({tag, "_seq_errs"}, 64'(errs), 64'(0));
        check({tag, "_done_cyc"}, 64'(done_at), 64'(e.done_cyc));
        check({tag, "_done_cnt"}, 64'(ndone), 64'(1));
        check({tag, "_last_addr"}, 64'(last), 64'(e.last_addr));
    endtask

    int fg [3];
    int ng [3];
    int dn [3];

    task automatic watch(input int n, input int inj, input logic iw,
                         input logic ie);
        logic [2:0] g, d;
        for (int k = 0; k < 3; k++) begin fg[k] = 0; ng[k] = 0; dn[k] = 0; end
        for (int cyc = 1; cyc <= n; cyc++) begin
            tick();
            if (cyc == inj) begin
                if (iw) bus.w_req = 1'b1;
                if (ie) bus.e_req = 1'b1;
            end
            #1;
            g = {bus.e_gnt, bus.c_gnt, bus.w_gnt};
            d = {bus.e_done, bus.c_done, bus.w_done};
            for (int k = 0; k < 3; k++) begin
                if (g[k]) begin
                    ng[k]++;
                    if (fg[k] == 0) fg[k] = cyc;
                end
                if (d[k]) dn[k] = cyc;
            end
            if (d[0]) bus.w_req = 1'b0;
            if (d[1]) bus.c_req = 1'b0;
            if (d[2]) bus.e_req = 1'b0;
        end
    endtask

    logic        ron   [3];
    logic [7:0]  rbase [3];
    int          rlen  [3];
    logic        pd    [3];
    logic [17:0] q [$];

    task automatic model_step();
        int win, l;
        if (q.size() != 0) return;
        q.push_back('0);
        win = -1;
        if (ron[0]) win = 0;
        else if (ron[1] && ron[2]) win = favor_e ? 2 : 1;
        else if (ron[1]) win = 1;
        else if (ron[2]) win = 2;
        if (win < 0) return;
        if (win != 0) favor_e = (win == 1);
        l = rlen[win];
        if (l == 0) begin
            q.push_back(mk(win, 0, 0, 1, 0, 0, 8'h00));
        end else if (win == 0) begin
            for (int i = 0; i < l; i++)
                q.push_back(mk(0, 1, 0, i == l - 1, 1, 0, rbase[0] + 8'(i)));
        end else begin
            for (int i = 0; i < l; i++)
                q.push_back(mk(win, 1, i > 0, 0, 0, 1, rbase[win] + 8'(i)));
            q.push_back(mk(win, 0, 1, 1, 0, 0, 8'h00));
        end
    endtask

    task automatic drive_agents();
        bus.w_req = ron[0]; bus.w_base = rbase[0]; bus.w_len = LW'(rlen[0]);
        bus.c_req = ron[1]; bus.c_base = rbase[1]; bus.c_len = LW'(rlen[1]);
        bus.e_req = ron[2]; bus.e_base = rbase[2]; bus.e_len = LW'(rlen[2]);
    endtask

    task automatic run_random(input int n);
        logic [17:0] e, act;
        logic [DW-1:0] gx, gy;
        gx = '0; gy = '0;
        for (int k = 0; k < 3; k++) begin
            ron[k] = 0; rbase[k] = 0; rlen[k] = 0; pd[k] = 0;
        end
        q.delete();
        for (int cyc = 0; cyc < n; cyc++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                if (pd[k]) begin
                    ron[k] = 1'b0;
                end else if (!ron[k] && $urandom_range(0, 3) == 0) begin
                    ron[k] = 1'b1;
                    rbase[k] = 8'($urandom);
                    if ($urandom_range(0, 15) == 0) rlen[k] = $urandom_range(10, 40);
                    else rlen[k] = $urandom_range(0, 9);
                end
            end
            drive_agents();
            bus.w_x = DW'($urandom);
            bus.w_y = DW'($urandom);
            model_step();
            e = q.pop_front();
            #1;
            act = outs();
            check("rand_cycle", 64'(act), 64'(e));
            if (e[14] || e[11]) begin
                check("rand_rd_x", 64'(bus.rd_x), 64'(gx));
                check("rand_rd_y", 64'(bus.rd_y), 64'(gy));
            end
            if (e[9]) begin
                check("rand_wx", 64'({bus.mem_wx, bus.mem_wy}), 64'({bus.w_x, bus.w_y}));
                ex_x[e[7:0]] = bus.w_x;
                ex_y[e[7:0]] = bus.w_y;
            end
            if (e[8]) begin
                gx = ex_x[e[7:0]];
                gy = ex_y[e[7:0]];
            end
            pd[0] = e[16];
            pd[1] = e[13];
            pd[2] = e[10];
        end
    endtask

    vec_t tbl [6];

    initial begin
        tbl[0] = '{who: 0, base: 8'h10, len: 4,   done_cyc: 4,   last_addr: 8'h13};
        tbl[1] = '{who: 1, base: 8'h20, len: 3,   done_cyc: 4,   last_addr: 8'h22};
        tbl[2] = '{who: 2, base: 8'hFE, len: 4,   done_cyc: 5,   last_addr: 8'h01};
        tbl[3] = '{who: 1, base: 8'h40, len: 0,   done_cyc: 1,   last_addr: 8'h00};
        tbl[4] = '{who: 0, base: 8'hFF, len: 2,   done_cyc: 2,   last_addr: 8'h00};
        tbl[5] = '{who: 2, base: 8'h80, len: 256, done_cyc: 257, last_addr: 8'h7F};

        do_reset();
        for (int i = 0; i < 6; i++)
            run_entry($sformatf("tbl%0d", i), tbl[i]);

        // C and E requested together: C first, E at the following IDLE
        do_reset();
        tick();
        set_req(1, 1'b1, 8'h40, 3);
        set_req(2, 1'b1, 8'h60, 3);
        watch(14, 0, 1'b0, 1'b0);
        check("ce_c_first_gnt", 64'(fg[1]), 64'(1));
        check("ce_c_done", 64'(dn[1]), 64'(4));
        check("ce_e_first_gnt", 64'(fg[2]), 64'(6));
        check("ce_e_done", 64'(dn[2]), 64'(9));
        check("ce_e_gnt_cnt", 64'(ng[2]), 64'(3));

        // W arrives mid C burst; wins next IDLE over pending E
        do_reset();
        tick();
        set_req(1, 1'b1, 8'h30, 4);
        bus.w_base = 8'h50; bus.w_len = 2;
        bus.e_base = 8'h70; bus.e_len = 2;
        watch(16, 2, 1'b1, 1'b1);
        check("wmid_c_gnt_cnt", 64'(ng[1]), 64'(4));
        check("wmid_c_done", 64'(dn[1]), 64'(5));
        check("wmid_w_first_gnt", 64'(fg[0]), 64'(7));
        check("wmid_w_done", 64'(dn[0]), 64'(8));
        check("wmid_e_first_gnt", 64'(fg[2]), 64'(10));
        check("wmid_e_done", 64'(dn[2]), 64'(12));

        // reset in the 2nd cycle of an 8-word E burst
        do_reset();
        tick();
        set_req(2, 1'b1, 8'h00, 8);
        tick();
        #1;
        check("rst_mid_pre_gnt", 64'(bus.e_gnt), 64'(1));
        tick();
        rst = 1'b1;
        bus.e_req = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("rst_mid_outs_zero", 64'(outs()), 64'(0));
        watch(6, 0, 1'b0, 1'b0);
        check("rst_mid_no_e_done", 64'(dn[2]), 64'(0));
        check("rst_mid_no_e_gnt", 64'(ng[2]), 64'(0));
        run_entry("rst_mid_fresh_c", '{who: 1, base: 8'h90, len: 2,
                                       done_cyc: 3, last_addr: 8'h91});

        // reset returns the round-robin pointer to C
        do_reset();
        tick();
        set_req(1, 1'b1, 8'h00, 1);
        watch(4, 0, 1'b0, 1'b0);
        do_reset();
        tick();
        set_req(1, 1'b1, 8'h05, 1);
        set_req(2, 1'b1, 8'h06, 1);
        watch(8, 0, 1'b0, 1'b0);
        check("rr_rst_c_first", 64'(fg[1]), 64'(1));
        check("rr_rst_e_second", 64'(fg[2]), 64'(4));

        do_reset();
        run_random(1500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
